// File: rtl/text_ram_arbiter_pkg.sv
// Shared constants and grant-state encodings for the text RAM arbiter.
// Optional clear engine: TEXT_ARBITER_CLEAR_EN adds the CLEAR_WR grant state.
package text_ram_arbiter_pkg;

  localparam int TEXT_COLS  = 100;
  localparam int TEXT_ROWS  = 60;
  localparam int COL_W      = 7;
  localparam int ROW_W      = 6;
  localparam int ADDR_W     = 13;
  localparam int CHAR_W     = 8;
  localparam int FIFO_DEPTH = 8;

`ifdef TEXT_ARBITER_CLEAR_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISP_RD  = 2'd1,
    HOST_WR  = 2'd2,
    CLEAR_WR = 2'd3
  } grant_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISP_RD = 2'd1,
    HOST_WR = 2'd2
  } grant_t;
`endif

endpackage

// File: rtl/text_write_fifo.sv
// Synchronous FIFO holding queued host writes as {addr, char} entries.
// The caller guarantees no push while full and no pop while empty.
module text_write_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Entry storage; contents need no reset since level gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; simultaneous push/pop leaves level unchanged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/text_ram_arbiter.sv
// Shares the single-port character RAM between the display fetch path and
// a FIFO-buffered host write port. Display reads always win the RAM cycle.
// Build option: define TEXT_ARBITER_CLEAR_EN for the screen-clear engine
// (clear_req/clear_busy ports, CLEAR_WR grant state).
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | RAM unused this cycle, ram_addr held
// DISP_RD  | display fetch address presented, read in flight
// HOST_WR  | head of host FIFO written to RAM
// CLEAR_WR | clear engine writes fill byte at its counter address
module text_ram_arbiter
  import text_ram_arbiter_pkg::*;
#(
  parameter int TEXT_COLS  = text_ram_arbiter_pkg::TEXT_COLS,
  parameter int TEXT_ROWS  = text_ram_arbiter_pkg::TEXT_ROWS,
  parameter int COL_W      = text_ram_arbiter_pkg::COL_W,
  parameter int ROW_W      = text_ram_arbiter_pkg::ROW_W,
  parameter int ADDR_W     = text_ram_arbiter_pkg::ADDR_W,
  parameter int FIFO_DEPTH = text_ram_arbiter_pkg::FIFO_DEPTH
`ifdef TEXT_ARBITER_CLEAR_EN
  , parameter logic [7:0] CLEAR_CHAR = 8'h20
`endif
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          disp_load,
  input  logic [COL_W-1:0]              disp_xtext,
  input  logic [ROW_W-1:0]              disp_ytext,
  output logic [7:0]                    disp_char,
  output logic                          disp_char_valid,
  input  logic                          host_valid,
  output logic                          host_ready,
  input  logic [COL_W-1:0]              host_col,
  input  logic [ROW_W-1:0]              host_row,
  input  logic [7:0]                    host_char,
  output logic                          host_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic                          ram_we,
  output logic [7:0]                    ram_wdata,
  input  logic [7:0]                    ram_rdata
`ifdef TEXT_ARBITER_CLEAR_EN
  , input  logic                        clear_req
  , output logic                        clear_busy
`endif
);

  localparam int ENTRY_W = ADDR_W + CHAR_W;

  grant_t               state;
  logic                 rd_pend;
  logic                 ready_en;
  logic [ADDR_W-1:0]    disp_addr;
  logic [ADDR_W-1:0]    host_addr;
  logic                 host_in_range;
  logic                 host_accept;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   fifo_dout;

`ifdef TEXT_ARBITER_CLEAR_EN
  localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(TEXT_COLS * TEXT_ROWS - 1);
  logic                 clear_run;
  logic [ADDR_W-1:0]    clear_cnt;
`endif

  // Indices are widened to the address width before the multiply
  assign disp_addr = ADDR_W'(disp_ytext) * ADDR_W'(TEXT_COLS) + ADDR_W'(disp_xtext);
  assign host_addr = ADDR_W'(host_row)   * ADDR_W'(TEXT_COLS) + ADDR_W'(host_col);

  assign host_in_range = (32'(host_col) < TEXT_COLS) && (32'(host_row) < TEXT_ROWS);
  assign host_ready    = ready_en && !fifo_full;
  assign host_accept   = host_valid && host_ready;
  assign fifo_push     = host_accept && host_in_range;

`ifdef TEXT_ARBITER_CLEAR_EN
  assign fifo_pop = !disp_load && !fifo_empty && !clear_busy;
`else
  assign fifo_pop = !disp_load && !fifo_empty;
`endif

  text_write_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     ({host_addr, host_char}),
    .dout    (fifo_dout),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Port-grant FSM: display, then clear engine, then queued host writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
`ifdef TEXT_ARBITER_CLEAR_EN
      clear_run  <= 1'b0;
      clear_busy <= 1'b0;
      clear_cnt  <= '0;
`endif
    end else begin
      if (disp_load) begin
        state    <= DISP_RD;
        ram_we   <= 1'b0;
        ram_addr <= disp_addr;
      end
`ifdef TEXT_ARBITER_CLEAR_EN
      else if (clear_run) begin
        state     <= CLEAR_WR;
        ram_we    <= 1'b1;
        ram_addr  <= clear_cnt;
        ram_wdata <= CLEAR_CHAR;
        clear_cnt <= clear_cnt + ADDR_W'(1);
        if (clear_cnt == CLEAR_LAST) clear_run <= 1'b0;
      end
`endif
      else if (fifo_pop) begin
        state     <= HOST_WR;
        ram_we    <= 1'b1;
        ram_addr  <= fifo_dout[ENTRY_W-1:CHAR_W];
        ram_wdata <= fifo_dout[CHAR_W-1:0];
      end else begin
        state  <= IDLE;
        ram_we <= 1'b0;
      end
`ifdef TEXT_ARBITER_CLEAR_EN
      // busy stays up through the cycle the last clear write is on the bus
      if (clear_req && !clear_busy) begin
        clear_busy <= 1'b1;
        clear_run  <= 1'b1;
        clear_cnt  <= '0;
      end else if (clear_busy && !clear_run) begin
        clear_busy <= 1'b0;
      end
`endif
    end
  end

  // Display return path: address out in N+1, data captured end of N+2
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend         <= 1'b0;
      disp_char_valid <= 1'b0;
      disp_char       <= '0;
    end else begin
      rd_pend         <= (state == DISP_RD);
      disp_char_valid <= rd_pend;
      if (rd_pend) disp_char <= ram_rdata;
    end
  end

  // Host side: ready comes up the cycle after reset, error flags dropped writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en <= 1'b0;
      host_err <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      host_err <= host_accept && !host_in_range;
    end
  end

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Directed and randomized checks of text_ram_arbiter against a RAM model
// and a queue-based reference of expected writes and display fetches.
`timescale 1ns/1ps
module tb_text_ram_arbiter;

  localparam int COLS = 100;
  localparam int AW   = 13;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        disp_load = 1'b0;
  logic [6:0]  disp_xtext = '0;
  logic [5:0]  disp_ytext = '0;
  logic [7:0]  disp_char;
  logic        disp_char_valid;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [6:0]  host_col = '0;
  logic [5:0]  host_row = '0;
  logic [7:0]  host_char = '0;
  logic        host_err;
  logic [3:0]  fifo_level;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
`ifdef TEXT_ARBITER_CLEAR_EN
  logic        clear_req = 1'b0;
  logic        clear_busy;
`endif

  always #10 clk = ~clk;

  text_ram_arbiter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .disp_load       (disp_load),
    .disp_xtext      (disp_xtext),
    .disp_ytext      (disp_ytext),
    .disp_char       (disp_char),
    .disp_char_valid (disp_char_valid),
    .host_valid      (host_valid),
    .host_ready      (host_ready),
    .host_col        (host_col),
    .host_row        (host_row),
    .host_char       (host_char),
    .host_err        (host_err),
    .fifo_level      (fifo_level),
    .ram_addr        (ram_addr),
    .ram_we          (ram_we),
    .ram_wdata       (ram_wdata),
    .ram_rdata       (ram_rdata)
`ifdef TEXT_ARBITER_CLEAR_EN
    , .clear_req     (clear_req)
    , .clear_busy    (clear_busy)
`endif
  );

  // Initial RAM image: a fixed pattern with 'A' planted at row 2, col 5
  function automatic logic [7:0] pat(input logic [12:0] a);
    if (a == 13'd205) return 8'h41;
    return a[7:0] ^ 8'h5A;
  endfunction

  logic [7:0] mem [0:8191];
  logic       preload = 1'b1;

  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 8192; a++) mem[a] <= pat(13'(a));
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: expected RAM writes in acceptance order, fetches with their strobe cycle
  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         wq[$];
  int          rq_cyc[$];
  logic [12:0] rq_addr[$];
  int          eq[$];
  bit          mon_en = 1'b0;
  wr_t         mw;
  int          mc;
  logic [12:0] ma;

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (ram_we) begin
        chk("wr_expected", 32'(wq.size() > 0), 32'd1);
        if (wq.size() > 0) begin
          mw = wq.pop_front();
          chk("wr_addr", 32'(ram_addr), 32'(mw.addr));
          chk("wr_data", 32'(ram_wdata), 32'(mw.data));
        end
      end
      if (disp_char_valid) begin
        chk("rd_expected", 32'(rq_cyc.size() > 0), 32'd1);
        if (rq_cyc.size() > 0) begin
          mc = rq_cyc.pop_front();
          ma = rq_addr.pop_front();
          chk("rd_latency", 32'(cyc), 32'(mc + 3));
          chk("rd_char", 32'(disp_char), 32'(pat(ma)));
        end
      end
      if (host_err) begin
        chk("err_expected", 32'(eq.size() > 0), 32'd1);
        if (eq.size() > 0) chk("err_cycle", 32'(cyc), 32'(eq.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  int          we_cnt;
  bit          have;
  int          r, c, i;
  logic [7:0]  d;

  initial begin
    // ---- reset state ----
    step(3);
    chk("rst_disp_char", 32'(disp_char), 32'd0);
    chk("rst_valid", 32'(disp_char_valid), 32'd0);
    chk("rst_host_err", 32'(host_err), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_host_ready", 32'(host_ready), 32'd0);
    preload = 1'b0;
    reset_n = 1'b1;
    step(1);
    chk("post_rst_ready", 32'(host_ready), 32'd1);

    // ---- single display fetch at col 5, row 2 ----
    disp_load = 1'b1; disp_xtext = 7'd5; disp_ytext = 6'd2;
    step(1);
    disp_load = 1'b0;
    chk("fetch_addr", 32'(ram_addr), 32'd205);
    chk("fetch_we", 32'(ram_we), 32'd0);
    step(1);
    chk("fetch_valid_n2", 32'(disp_char_valid), 32'd0);
    step(1);
    chk("fetch_valid_n3", 32'(disp_char_valid), 32'd1);
    chk("fetch_char", 32'(disp_char), 32'h41);
    step(1);
    chk("fetch_valid_n4", 32'(disp_char_valid), 32'd0);

    // ---- corner write (99,59) ----
    host_valid = 1'b1; host_col = 7'd99; host_row = 6'd59; host_char = 8'h7E;
    step(1);
    host_valid = 1'b0;
    chk("corner_level", 32'(fifo_level), 32'd1);
    chk("corner_we_early", 32'(ram_we), 32'd0);
    step(1);
    chk("corner_we", 32'(ram_we), 32'd1);
    chk("corner_addr", 32'(ram_addr), 32'd5999);
    chk("corner_wdata", 32'(ram_wdata), 32'h7E);
    chk("corner_level0", 32'(fifo_level), 32'd0);
    step(1);
    chk("corner_we_off", 32'(ram_we), 32'd0);
    chk("corner_mem", 32'(mem[5999]), 32'h7E);

    // ---- fill FIFO while display holds the RAM ----
    disp_load = 1'b1; disp_xtext = '0; disp_ytext = '0;
    for (int k = 0; k < 8; k++) begin
      host_valid = 1'b1; host_col = 7'(k * 3); host_row = 6'(40 + k); host_char = 8'hA0 + 8'(k);
      step(1);
      chk("fill_we", 32'(ram_we), 32'd0);
    end
    host_valid = 1'b0;
    chk("full_level", 32'(fifo_level), 32'd8);
    chk("full_ready", 32'(host_ready), 32'd0);
    step(2);
    chk("full_hold_we", 32'(ram_we), 32'd0);
    chk("full_hold_level", 32'(fifo_level), 32'd8);
    disp_load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("drain_we", 32'(ram_we), 32'd1);
      chk("drain_addr", 32'(ram_addr), 32'((40 + k) * COLS + k * 3));
      chk("drain_data", 32'(ram_wdata), 32'hA0 + 32'(k));
    end
    step(1);
    chk("drain_done_we", 32'(ram_we), 32'd0);
    chk("drain_done_level", 32'(fifo_level), 32'd0);
    step(4);

    // ---- display strobe collides with a due pop ----
    host_valid = 1'b1; host_col = 7'd7; host_row = 6'd33; host_char = 8'h55;
    step(1);
    host_valid = 1'b0;
    disp_load = 1'b1; disp_xtext = 7'd1; disp_ytext = 6'd1;
    step(1);
    disp_load = 1'b0;
    chk("coll_disp_we", 32'(ram_we), 32'd0);
    chk("coll_disp_addr", 32'(ram_addr), 32'd101);
    chk("coll_level", 32'(fifo_level), 32'd1);
    step(1);
    chk("coll_host_we", 32'(ram_we), 32'd1);
    chk("coll_host_addr", 32'(ram_addr), 32'd3307);
    chk("coll_host_data", 32'(ram_wdata), 32'h55);
    step(4);

    // ---- out-of-range writes ----
    host_valid = 1'b1; host_col = 7'd100; host_row = 6'd0; host_char = 8'h11;
    step(1);
    host_valid = 1'b0;
    chk("col_err", 32'(host_err), 32'd1);
    chk("col_err_level", 32'(fifo_level), 32'd0);
    step(1);
    chk("col_err_pulse", 32'(host_err), 32'd0);
    chk("col_err_we", 32'(ram_we), 32'd0);
    host_valid = 1'b1; host_col = 7'd0; host_row = 6'd60;
    step(1);
    host_valid = 1'b0;
    chk("row_err", 32'(host_err), 32'd1);
    step(1);
    chk("row_err_pulse", 32'(host_err), 32'd0);
    chk("row_err_level", 32'(fifo_level), 32'd0);

    // ---- throughput: strobe every 8 cycles with continuous host stream ----
    mon_en = 1'b1;
    have = 1'b0;
    we_cnt = 0;
    for (int t = 0; t < 160; t++) begin
      disp_load = ((t % 8) == 0);
      if (disp_load) begin
        disp_xtext = 7'($urandom_range(0, 99));
        disp_ytext = 6'($urandom_range(0, 29));
        rq_cyc.push_back(cyc);
        rq_addr.push_back(13'(int'(disp_ytext) * COLS + int'(disp_xtext)));
      end
      if (!have) begin
        host_col = 7'($urandom_range(0, 99));
        host_row = 6'($urandom_range(30, 59));
        host_char = 8'($urandom);
        have = 1'b1;
      end
      host_valid = 1'b1;
      if (host_ready) begin
        wq.push_back({13'(int'(host_row) * COLS + int'(host_col)), host_char});
        have = 1'b0;
      end
      step(1);
      if (t >= 80 && ram_we) we_cnt++;
    end
    chk("throughput_7_of_8", 32'(we_cnt), 32'd70);

    // ---- randomized mix ----
    for (int t = 0; t < 400; t++) begin
      disp_load = ($urandom_range(0, 3) == 0);
      if (disp_load) begin
        disp_xtext = 7'($urandom_range(0, 99));
        disp_ytext = 6'($urandom_range(0, 29));
        rq_cyc.push_back(cyc);
        rq_addr.push_back(13'(int'(disp_ytext) * COLS + int'(disp_xtext)));
      end
      host_valid = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 15);
      if (r == 0) begin
        host_col = 7'($urandom_range(100, 127)); host_row = 6'($urandom_range(0, 63));
      end else if (r == 1) begin
        host_col = 7'($urandom_range(0, 99)); host_row = 6'($urandom_range(60, 63));
      end else begin
        host_col = 7'($urandom_range(0, 99)); host_row = 6'($urandom_range(30, 59));
      end
      host_char = 8'($urandom);
      if (host_valid && host_ready) begin
        if (r <= 1) eq.push_back(cyc + 1);
        else wq.push_back({13'(int'(host_row) * COLS + int'(host_col)), host_char});
      end
      step(1);
    end
    disp_load = 1'b0;
    host_valid = 1'b0;
    c = 0;
    while ((wq.size() != 0 || rq_cyc.size() != 0 || eq.size() != 0) && c < 50) begin
      step(1);
      c++;
    end
    chk("random_drained", 32'(wq.size() + rq_cyc.size() + eq.size()), 32'd0);
    step(2);
    mon_en = 1'b0;

    // ---- reset during a pending fetch with three queued writes ----
    disp_load = 1'b1; disp_xtext = 7'd9; disp_ytext = 6'd4;
    for (int k = 0; k < 3; k++) begin
      host_valid = 1'b1; host_col = 7'(k); host_row = 6'd50; host_char = 8'hC0;
      step(1);
    end
    host_valid = 1'b0;
    disp_load = 1'b0;
    chk("pre_rst_level", 32'(fifo_level), 32'd3);
    reset_n = 1'b0;
    #1;
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_ram_addr", 32'(ram_addr), 32'd0);
    chk("arst_valid", 32'(disp_char_valid), 32'd0);
    chk("arst_ready", 32'(host_ready), 32'd0);
    step(2);
    reset_n = 1'b1;
    i = 0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (disp_char_valid || ram_we || fifo_level != 0) i++;
    end
    chk("post_rst_quiet", 32'(i), 32'd0);
    chk("post_rst_char", 32'(disp_char), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_ram_arbiter.md
Name: text_ram_arbiter

Overview:
- Shares one single-port synchronous character RAM (TEXT_COLS x TEXT_ROWS bytes) between two requesters:
  - the display fetch path, driven by the 800x600 timing generator's clk_load_char strobe and xtext/ytext;
  - a host write port with a valid/ready handshake and a small write FIFO.
- Display reads have absolute priority. Host writes drain in the remaining RAM cycles.
- Sits between the timing generator, the text RAM and the host/CPU bus.

Parameters:
- TEXT_COLS, 100, characters per row (800/8)
- TEXT_ROWS, 60, character rows (600/10)
- COL_W, 7, width of column indices
- ROW_W, 6, width of row indices
- ADDR_W, 13, RAM address width (must satisfy 2^ADDR_W >= TEXT_COLS*TEXT_ROWS)
- FIFO_DEPTH, 8, host write FIFO entries (power of two, >= 2)
- CLEAR_CHAR, 8'h20, fill byte for the clear engine (optional feature only)

Ports:
- clk  in  1  pixel clock, 50 MHz
- reset_n  in  1  asynchronous reset, active-low
- disp_load  in  1  fetch strobe (clk_load_char), one cycle per character
- disp_xtext  in  COL_W  character column to fetch
- disp_ytext  in  ROW_W  character row to fetch
- disp_char  out  8  fetched character code
- disp_char_valid  out  1  one-cycle pulse; disp_char is valid
- host_valid  in  1  host write request
- host_ready  out  1  FIFO not full
- host_col  in  COL_W  write column
- host_row  in  ROW_W  write row
- host_char  in  8  write data
- host_err  out  1  one-cycle pulse: out-of-range write dropped
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
- ram_addr  out  ADDR_W  registered RAM address
- ram_we  out  1  registered RAM write enable
- ram_wdata  out  8  registered RAM write data
- ram_rdata  in  8  RAM read data, valid one cycle after the address is presented

Behaviour:
- Reset (reset_n low, asynchronous) clears all of the following to 0: disp_char, disp_char_valid, host_err, fifo_level, ram_addr, ram_we, ram_wdata.
  - FIFO pointers are cleared.
  - In-flight display reads are discarded: no valid pulse is produced after reset.
  - host_ready is 0 while reset_n is low and 1 from the first cycle after release.
- Address: row*TEXT_COLS + col, computed at ADDR_W bits. Inputs are never truncated before the multiply.
- Host accept:
  - A write is accepted when host_valid && host_ready at a clock edge; host_ready = (fifo_level != FIFO_DEPTH).
  - If col >= TEXT_COLS or row >= TEXT_ROWS, the write is accepted but not queued, and host_err pulses in the next cycle.
- Port-grant FSM, evaluated every cycle. Each state lasts exactly one cycle:
  - DISP_RD when disp_load=1: ram_we<=0, ram_addr<=display address.
  - HOST_WR when disp_load=0 and the FIFO is not empty: pop the head entry; ram_we<=1, ram_addr/ram_wdata<=entry.
  - IDLE otherwise: ram_we<=0, ram_addr holds its previous value.
- Display latency:
  - disp_load in cycle N → RAM address presented in N+1 → ram_rdata captured into disp_char at the end of N+2 → disp_char_valid=1 during N+3 only.
  - The fixed 3-cycle latency fits inside the timing generator's 7-cycle load-ahead.
  - Back-to-back disp_load strobes are supported, one result per strobe, in order.
- Simultaneous push and pop in the same cycle: fifo_level is unchanged.
  - A push while full cannot occur, because host_ready is low when full.
  - A pop while empty cannot occur, because HOST_WR requires a non-empty FIFO.
- Host writes are committed to RAM in acceptance order. A host write is never lost due to display collisions; it is only delayed.
- Display reads never stall. With a strobe every 8 cycles, host throughput is at least 7 writes per 8 cycles.

Optional Feature:
- Macro: TEXT_ARBITER_CLEAR_EN.
- When defined, two extra ports exist:
  - clear_req  in  1  pulse; start a screen clear
  - clear_busy  out  1  clear in progress
- clear_req while not busy starts a counter at address 0 and sets clear_busy the next cycle.
- Grant priority becomes display > clear > host. The clear state CLEAR_WR writes CLEAR_CHAR to the counter address, then increments the counter.
- clear_busy drops in the cycle after address TEXT_COLS*TEXT_ROWS-1 is written.
- clear_req while busy is ignored. The FIFO still accepts writes during a clear but does not drain until the clear completes.
- Reset aborts a clear: clear_busy=0.
- When the macro is undefined: the ports are absent, the CLEAR_WR state is absent, and no clear logic is generated.

Decomposition:
- Shared package/header constant.vh holds: TEXT_COLS, TEXT_ROWS, COL_W, ROW_W, ADDR_W, the character width (8), and the grant-state encodings (IDLE, DISP_RD, HOST_WR, CLEAR_WR).
- One sub-module: text_write_fifo. It is a synchronous FIFO with push, pop, din, dout, level, full and empty, of width ADDR_W+8 and depth FIFO_DEPTH.

Test Plan:
- disp_load pulse at col=5, row=2, with RAM preloaded [205]=8'h41 → ram_addr=205 one cycle later; disp_char=8'h41 with disp_char_valid high exactly 3 cycles after the strobe.
- Host writes (99,59,8'h7E) with the display idle → ram_we=1, ram_addr=5999, ram_wdata=8'h7E two cycles after acceptance.
- 8 host writes pushed while disp_load is held high continuously → host_ready=0 after the 8th write, fifo_level=8, ram_we stays 0. Releasing disp_load drains all 8 writes in order over 8 cycles.
- disp_load and host pop due in the same cycle → DISP_RD is granted and the write follows in the next free cycle. A strobe every 8 cycles with a continuous host stream yields 7 writes per 8 cycles.
- Host write with col=100 → not queued, host_err pulses once, fifo_level unchanged.
- reset_n asserted during a pending display read with FIFO level 3 → all outputs 0, no disp_char_valid pulse, fifo_level=0. With TEXT_ARBITER_CLEAR_EN defined, a clear runs 6000 writes of 8'h20 and clear_busy spans them.
